// File: rtl/test_spi_device_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : test_spi_device_pkg
//  Description : Shared constants and types for the SPI loopback target.
//  Revision    : 1.0 - initial release
// ============================================================================
package test_spi_device_pkg;

    localparam int SPI_FRAME_BITS = 8;
    localparam int SPI_CNT_W      = $clog2(SPI_FRAME_BITS);

    typedef logic [SPI_FRAME_BITS-1:0] spi_byte_t;
    typedef logic [SPI_CNT_W-1:0]      spi_cnt_t;

    // Byte returned in the first frame after reset.
    localparam spi_byte_t SPI_RESET_TX = 8'h00;

    // Index of the last bit position in a frame.
    localparam spi_cnt_t SPI_LAST_BIT = SPI_CNT_W'(SPI_FRAME_BITS - 1);

endpackage : test_spi_device_pkg
`default_nettype wire

// File: rtl/test_spi_device_shift_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shift_rx
//  Description : Serial-in shift register with free-running frame bit
//                counter. Presents the complete byte (including the bit on
//                the wire now) and a frame-done strobe on the last bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_rx
    import test_spi_device_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      bit_i,
    output spi_cnt_t  bit_cnt_o,
    output spi_byte_t byte_o,
    output logic      frame_done_o
);

    spi_cnt_t                  cnt_q, cnt_d;
    logic [SPI_FRAME_BITS-2:0] sh_q,  sh_d;

    // Next-state: shift in the sampled bit, advance the counter (wraps 7 -> 0).
    always_comb begin
        cnt_d = cnt_q + spi_cnt_t'(1);
        sh_d  = {sh_q[SPI_FRAME_BITS-3:0], bit_i};
    end

    // State register; reset discards any partial byte and realigns the frame.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    assign bit_cnt_o    = cnt_q;
    // On the last bit of a frame the bit on the wire completes the byte.
    assign byte_o       = {sh_q, bit_i};
    assign frame_done_o = (cnt_q == SPI_LAST_BIT);

endmodule : spi_shift_rx
`default_nettype wire

// File: rtl/test_spi_device.sv
`default_nettype none
// ============================================================================
//  Module      : test_spi_device
//  Description : SPI mode-0 slave loopback. Each byte received on MOSI is
//                returned MSB first on MISO during the following frame.
//                No chip select: frames are aligned by a counter from reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_spi_device
    import test_spi_device_pkg::*;
(
    input  logic sck,
    input  logic reset,
    input  logic mosi,
    output logic miso
);

    spi_cnt_t  bit_cnt;
    spi_byte_t rx_byte;
    logic      frame_done;

    spi_byte_t tx_byte_q, tx_byte_d;
    logic      miso_q,    miso_d;

    spi_shift_rx u_shift_rx (
        .clk_i        (sck),
        .rst_ni       (reset),
        .bit_i        (mosi),
        .bit_cnt_o    (bit_cnt),
        .byte_o       (rx_byte),
        .frame_done_o (frame_done)
    );

    // Next-state: MISO walks the held byte MSB first; the held byte is
    // replaced on the last bit, so this edge still sends the old bit 0.
    always_comb begin
        miso_d    = tx_byte_q[SPI_LAST_BIT - bit_cnt];
        tx_byte_d = tx_byte_q;
        if (frame_done) begin
            tx_byte_d = rx_byte;
        end
    end

    // Output and echo-byte registers.
    always_ff @(posedge sck) begin
        if (!reset) begin
            tx_byte_q <= SPI_RESET_TX;
            miso_q    <= 1'b0;
        end else begin
            tx_byte_q <= tx_byte_d;
            miso_q    <= miso_d;
        end
    end

    assign miso = miso_q;

endmodule : test_spi_device
`default_nettype wire

// File: tb/tb_test_spi_device.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_spi_device
//  Description : Self-checking bench for the SPI loopback target. A queue of
//                pending echo bytes models the device at frame level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_spi_device;

    logic sck;
    logic reset;
    logic mosi;
    logic miso;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level model: the byte at the head is what the next frame returns.
    logic [7:0] echo_q[$];

    test_spi_device dut (
        .sck   (sck),
        .reset (reset),
        .mosi  (mosi),
        .miso  (miso)
    );

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model of a reset: partial frame lost, next frame returns the reset byte.
    function automatic void model_reset();
        echo_q.delete();
        echo_q.push_back(8'h00);
    endfunction

    // Clock nbits of tx onto MOSI (entered and left with sck low).
    // glitch: flip MOSI during the high phase. chk_bits: check each MISO bit
    // against exp and that it is steady from rise to fall.
    task automatic drive_bits(input logic [7:0] tx, input int nbits, input bit glitch,
                              input bit chk_bits, input logic [7:0] exp,
                              output logic [7:0] rx);
        logic a;
        logic b;
        rx = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi = tx[7-k];
            @(posedge sck);
            #1;
            a = miso;
            if (glitch) mosi = ~mosi;
            @(negedge sck);
            b = miso;
            rx = {rx[6:0], b};
            if (chk_bits) begin
                chk($sformatf("stable_bit%0d", k), {31'd0, a}, {31'd0, exp[7-k]});
                chk($sformatf("miso_bit%0d", k), {31'd0, b}, {31'd0, exp[7-k]});
            end
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] tx, input bit glitch,
                              input bit chk_bits);
        logic [7:0] exp;
        logic [7:0] rx;
        exp = (echo_q.size() > 0) ? echo_q.pop_front() : 8'h00;
        drive_bits(tx, 8, glitch, chk_bits, exp, rx);
        echo_q.push_back(tx);
        chk(tag, {24'd0, rx}, {24'd0, exp});
    endtask

    // One sck rise with reset low.
    task automatic pulse_reset();
        mosi   = 1'($urandom);
        reset  = 1'b0;
        @(posedge sck);
        @(negedge sck);
        chk("reset_miso", {31'd0, miso}, 32'd0);
        reset  = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] b;
        reset = 1'b0;
        mosi  = 1'b0;
        model_reset();

        // Initial reset over two rises.
        @(negedge sck);
        @(negedge sck);
        chk("por_miso", {31'd0, miso}, 32'd0);
        reset = 1'b1;

        // Directed: 3C then FF.
        send_frame("f_3C", 8'h3C, 1'b0, 1'b0);
        send_frame("f_FF", 8'hFF, 1'b0, 1'b0);

        // Counting sweep 00..FF, then closing 00.
        pulse_reset();
        for (int n = 0; n < 256; n++) begin
            send_frame($sformatf("sweep_%0d", n), 8'(n), 1'b0, 1'b0);
        end
        send_frame("sweep_end", 8'h00, 1'b0, 1'b0);

        // A5 then 5A with per-bit order and stability checks.
        send_frame("f_A5", 8'hA5, 1'b0, 1'b0);
        send_frame("f_5A", 8'h5A, 1'b0, 1'b1);

        // Partial frame, reset, then 81 and 00.
        drive_bits(8'hF0, 3, 1'b0, 1'b0, 8'h00, rx);
        pulse_reset();
        send_frame("post_rst_81", 8'h81, 1'b0, 1'b0);
        send_frame("post_rst_00", 8'h00, 1'b0, 1'b0);

        // MOSI toggling during the high phase must be ignored.
        send_frame("glitch_C3", 8'hC3, 1'b1, 1'b0);
        send_frame("after_glitch", 8'h00, 1'b0, 1'b0);

        // Reset held across a whole frame of 77: MISO stays 0.
        send_frame("pre_hold", 8'h99, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mosi = b_bit(8'h77, k);
            @(posedge sck);
            @(negedge sck);
            chk($sformatf("hold_miso%0d", k), {31'd0, miso}, 32'd0);
        end
        reset = 1'b1;
        model_reset();
        send_frame("after_hold", 8'h12, 1'b0, 1'b0);

        // Randomized frames with occasional glitches and resets.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(1) == 1) begin
                    drive_bits(8'($urandom), $urandom_range(7, 1), 1'b0, 1'b0, 8'h00, rx);
                end
                pulse_reset();
            end
            b = 8'($urandom);
            send_frame($sformatf("rand_%0d", n), b, 1'($urandom), 1'($urandom_range(3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic b_bit(input logic [7:0] v, input int k);
        return v[7-k];
    endfunction

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule : tb_test_spi_device
`default_nettype wire
